// File: rtl/sccomp_pkg.sv
// Shared encodings for the single-cycle MIPS-subset computer: opcodes, functs,
// ALU operations, next-PC and destination selects, plus the ALU itself.
package sccomp_pkg;

   // Primary opcodes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type function codes
   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SRA  = 6'h03;
   localparam logic [5:0] F_JR   = 6'h08;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_XOR  = 6'h26;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2A;
   localparam logic [5:0] F_SLTU = 6'h2B;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
      ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
   } alu_op_e;

   typedef enum logic [1:0] {
      NPC_PC4, NPC_BRANCH, NPC_JUMP, NPC_JR
   } npc_sel_e;

   typedef enum logic [1:0] {
      DST_RT, DST_RD, DST_RA
   } dst_sel_e;

   // 32-bit wrap-around ALU; shifts act on b by sh, LUI places b[15:0] high.
   function automatic logic [31:0] alu_eval(input alu_op_e op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
      logic [31:0] y;
      y = '0;
      case (op)
         ALU_ADD:  y = a + b;
         ALU_SUB:  y = a - b;
         ALU_AND:  y = a & b;
         ALU_OR:   y = a | b;
         ALU_XOR:  y = a ^ b;
         ALU_NOR:  y = ~(a | b);
         ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
         ALU_SLTU: y = {31'b0, a < b};
         ALU_SLL:  y = b << sh;
         ALU_SRL:  y = b >> sh;
         ALU_SRA:  y = $signed(b) >>> sh;
         ALU_LUI:  y = {b[15:0], 16'h0000};
         default:  y = '0;
      endcase
      return y;
   endfunction

endpackage

// File: rtl/dm.sv
// Data RAM: combinational read, synchronous write, never cleared by reset.
module dm #(
   parameter int unsigned DM_DEPTH = 128
) (
   input  logic                        clk,
   input  logic                        we,
   input  logic [$clog2(DM_DEPTH)-1:0] addr,
   input  logic [31:0]                 wdata,
   output logic [31:0]                 rdata
);

   logic [31:0] mem [DM_DEPTH-1:0];

   // Word store on rising edge
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/im.sv
// Instruction ROM, word-indexed; contents are loaded from outside the design.
module im #(
   parameter int unsigned IM_DEPTH = 128
) (
   input  logic [$clog2(IM_DEPTH)-1:0] addr,
   output logic [31:0]                 rdata
);

   logic [31:0] ROM [IM_DEPTH-1:0];

   assign rdata = ROM[addr];

endmodule

// File: rtl/rf.sv
// 32x32 register file: two operand read ports, one debug read port, one write port.
// Register 0 reads as zero and ignores writes.
module rf
   import sccomp_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   input  logic [4:0]  ra3,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   output logic [31:0] rd3
);

   logic [31:0] rf [31:0];

   // Register storage: async clear, write on rising edge unless targeting $0
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
      end else if (we && (wa != 5'd0)) begin
         rf[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == 5'd0) ? '0 : rf[ra1];
   assign rd2 = (ra2 == 5'd0) ? '0 : rf[ra2];
   assign rd3 = (ra3 == 5'd0) ? '0 : rf[ra3];

endmodule

// File: rtl/sccpu.sv
// Single-cycle CPU core: decode, ALU, next-PC logic, PC register and register file.
module sccpu
   import sccomp_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DM_AW    = 7
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [31:0]      instr,
   output logic [31:0]      pc_o,
   output logic             dm_we,
   output logic [DM_AW-1:0] dm_addr,
   output logic [31:0]      dm_wdata,
   input  logic [31:0]      dm_rdata,
   input  logic [4:0]       reg_sel,
   output logic [31:0]      reg_data
);

   logic [31:0] PC;
   logic [31:0] pc_d;

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm;
   logic [25:0] target;

   logic        reg_write, alu_src_imm, sign_ext, mem_to_reg, mem_write;
   alu_op_e     alu_op;
   npc_sel_e    npc_sel;
   dst_sel_e    dst_sel;

   logic [31:0] rs_val, rt_val, imm_sext, imm_ext, alu_b, alu_y, pc4, wd;
   logic [4:0]  wa;

   assign op     = instr[31:26];
   assign rs     = instr[25:21];
   assign rt     = instr[20:16];
   assign rd     = instr[15:11];
   assign shamt  = instr[10:6];
   assign funct  = instr[5:0];
   assign imm    = instr[15:0];
   assign target = instr[25:0];

   rf U_RF (
      .clk  (clk),
      .rstn (rstn),
      .ra1  (rs),
      .ra2  (rt),
      .ra3  (reg_sel),
      .we   (reg_write),
      .wa   (wa),
      .wd   (wd),
      .rd1  (rs_val),
      .rd2  (rt_val),
      .rd3  (reg_data)
   );

   // Decode: unknown opcodes/functs fall through to the all-off defaults (NOP)
   always_comb begin
      reg_write   = 1'b0;
      alu_src_imm = 1'b0;
      sign_ext    = 1'b1;
      mem_to_reg  = 1'b0;
      mem_write   = 1'b0;
      alu_op      = ALU_ADD;
      npc_sel     = NPC_PC4;
      dst_sel     = DST_RT;
      case (op)
         OP_RTYPE: begin
            dst_sel   = DST_RD;
            reg_write = 1'b1;
            case (funct)
               F_ADD, F_ADDU: alu_op = ALU_ADD;
               F_SUB, F_SUBU: alu_op = ALU_SUB;
               F_AND:         alu_op = ALU_AND;
               F_OR:          alu_op = ALU_OR;
               F_XOR:         alu_op = ALU_XOR;
               F_NOR:         alu_op = ALU_NOR;
               F_SLT:         alu_op = ALU_SLT;
               F_SLTU:        alu_op = ALU_SLTU;
               F_SLL:         alu_op = ALU_SLL;
               F_SRL:         alu_op = ALU_SRL;
               F_SRA:         alu_op = ALU_SRA;
               F_JR: begin
                  reg_write = 1'b0;
                  npc_sel   = NPC_JR;
               end
               default:       reg_write = 1'b0;
            endcase
         end
         OP_ADDI: begin
            reg_write   = 1'b1;
            alu_src_imm = 1'b1;
         end
         OP_SLTI: begin
            reg_write   = 1'b1;
            alu_src_imm = 1'b1;
            alu_op      = ALU_SLT;
         end
         OP_ANDI: begin
            reg_write   = 1'b1;
            alu_src_imm = 1'b1;
            sign_ext    = 1'b0;
            alu_op      = ALU_AND;
         end
         OP_ORI: begin
            reg_write   = 1'b1;
            alu_src_imm = 1'b1;
            sign_ext    = 1'b0;
            alu_op      = ALU_OR;
         end
         OP_LUI: begin
            reg_write   = 1'b1;
            alu_src_imm = 1'b1;
            alu_op      = ALU_LUI;
         end
         OP_LW: begin
            reg_write   = 1'b1;
            alu_src_imm = 1'b1;
            mem_to_reg  = 1'b1;
         end
         OP_SW: begin
            alu_src_imm = 1'b1;
            mem_write   = 1'b1;
         end
         OP_BEQ: if (rs_val == rt_val) npc_sel = NPC_BRANCH;
         OP_BNE: if (rs_val != rt_val) npc_sel = NPC_BRANCH;
         OP_J:   npc_sel = NPC_JUMP;
         OP_JAL: begin
            npc_sel   = NPC_JUMP;
            reg_write = 1'b1;
            dst_sel   = DST_RA;
         end
         default: ;
      endcase
   end

   // Datapath: operand select, ALU, writeback select and next PC
   always_comb begin
      imm_sext = {{16{imm[15]}}, imm};
      imm_ext  = sign_ext ? imm_sext : {16'h0000, imm};
      alu_b    = alu_src_imm ? imm_ext : rt_val;
      alu_y    = alu_eval(alu_op, rs_val, alu_b, shamt);
      pc4      = PC + 32'd4;

      case (dst_sel)
         DST_RD:  wa = rd;
         DST_RA:  wa = 5'd31;
         default: wa = rt;
      endcase

      if (mem_to_reg)           wd = dm_rdata;
      else if (dst_sel == DST_RA) wd = pc4;
      else                      wd = alu_y;

      case (npc_sel)
         NPC_BRANCH: pc_d = pc4 + {imm_sext[29:0], 2'b00};
         NPC_JUMP:   pc_d = {pc4[31:28], target, 2'b00};
         NPC_JR:     pc_d = rs_val;
         default:    pc_d = pc4;
      endcase
   end

   // Program counter: async reset to RESET_PC, one instruction per edge
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) PC <= RESET_PC;
      else       PC <= pc_d;
   end

   assign pc_o     = PC;
   assign dm_addr  = alu_y[DM_AW+1:2];
   assign dm_wdata = rt_val;
   // Stores are suppressed on any edge seen while reset is held
   assign dm_we    = mem_write & rstn;

endmodule

// File: rtl/sccomp.sv
// Simulation top: CPU core, instruction ROM and data RAM.
module sccomp
   import sccomp_pkg::*;
#(
   parameter int unsigned IM_DEPTH = 128,
   parameter int unsigned DM_DEPTH = 128,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [4:0]  reg_sel,
   output logic [31:0] reg_data
);

   localparam int unsigned IM_AW = $clog2(IM_DEPTH);
   localparam int unsigned DM_AW = $clog2(DM_DEPTH);

   logic [31:0]      PC;
   logic [31:0]      instr;
   logic             dm_we;
   logic [DM_AW-1:0] dm_addr;
   logic [31:0]      dm_wdata, dm_rdata;

   sccpu #(
      .RESET_PC (RESET_PC),
      .DM_AW    (DM_AW)
   ) U_SCPU (
      .clk      (clk),
      .rstn     (rstn),
      .instr    (instr),
      .pc_o     (PC),
      .dm_we    (dm_we),
      .dm_addr  (dm_addr),
      .dm_wdata (dm_wdata),
      .dm_rdata (dm_rdata),
      .reg_sel  (reg_sel),
      .reg_data (reg_data)
   );

   im #(
      .IM_DEPTH (IM_DEPTH)
   ) U_IM (
      .addr  (PC[IM_AW+1:2]),
      .rdata (instr)
   );

   dm #(
      .DM_DEPTH (DM_DEPTH)
   ) U_DM (
      .clk   (clk),
      .we    (dm_we),
      .addr  (dm_addr),
      .wdata (dm_wdata),
      .rdata (dm_rdata)
   );

endmodule

// File: tb/tb_sccomp.sv
// Directed program bench for sccomp with an expectation queue.
`timescale 1ns/1ps
module tb_sccomp;

   logic        clk;
   logic        rstn;
   logic [4:0]  reg_sel;
   logic [31:0] reg_data;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   typedef struct {
      string       tag;
      int          kind;   // 0: reg_data port, 1: PC, 2: rf[0] storage
      logic [4:0]  sel;
      logic [31:0] exp;
   } chk_t;

   chk_t sb[$];

   sccomp dut (
      .clk      (clk),
      .rstn     (rstn),
      .reg_sel  (reg_sel),
      .reg_data (reg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic exp_reg(input string tag, input logic [4:0] sel, input logic [31:0] v);
      chk_t c;
      c.tag = tag; c.kind = 0; c.sel = sel; c.exp = v;
      sb.push_back(c);
   endtask

   task automatic exp_pc(input string tag, input logic [31:0] v);
      chk_t c;
      c.tag = tag; c.kind = 1; c.sel = '0; c.exp = v;
      sb.push_back(c);
   endtask

   task automatic exp_rf0(input string tag);
      chk_t c;
      c.tag = tag; c.kind = 2; c.sel = '0; c.exp = '0;
      sb.push_back(c);
   endtask

   task automatic drain();
      chk_t c;
      logic [31:0] obs;
      while (sb.size() > 0) begin
         c = sb.pop_front();
         if (c.kind == 1) begin
            obs = dut.PC;
         end else if (c.kind == 2) begin
            obs = dut.U_SCPU.U_RF.rf[0];
         end else begin
            reg_sel = c.sel;
            #0.2;
            obs = reg_data;
         end
         n_vec++;
         assert (obs === c.exp) else begin
            n_bad++;
            $error("FAIL %s: observed %08h expected %08h", c.tag, obs, c.exp);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_main();
      for (int i = 0; i < 128; i++) dut.U_IM.ROM[i] = '0;
      dut.U_IM.ROM[0]  = 32'h20010005; // addi $1,$0,5
      dut.U_IM.ROM[1]  = 32'h20020003; // addi $2,$0,3
      dut.U_IM.ROM[2]  = 32'h00221827; // nor  $3,$1,$2
      dut.U_IM.ROM[3]  = 32'h00412022; // sub  $4,$2,$1
      dut.U_IM.ROM[4]  = 32'h0080282A; // slt  $5,$4,$0
      dut.U_IM.ROM[5]  = 32'h3C061234; // lui  $6,0x1234
      dut.U_IM.ROM[6]  = 32'h34C65678; // ori  $6,$6,0x5678
      dut.U_IM.ROM[7]  = 32'h30C7FFFF; // andi $7,$6,0xFFFF
      dut.U_IM.ROM[8]  = 32'h10210002; // beq  $1,$1,+2
      dut.U_IM.ROM[9]  = 32'h20090001; // addi $9,$0,1 (skipped)
      dut.U_IM.ROM[10] = 32'h20090002; // addi $9,$0,2 (skipped)
      dut.U_IM.ROM[11] = 32'hAC060008; // sw   $6,8($0)
      dut.U_IM.ROM[12] = 32'h0C000010; // jal  0x40
      dut.U_IM.ROM[13] = 32'h8C080008; // lw   $8,8($0)
      dut.U_IM.ROM[14] = 32'h14210005; // bne  $1,$1,+5 (not taken)
      dut.U_IM.ROM[15] = 32'h08000011; // j    0x44
      dut.U_IM.ROM[16] = 32'h03E00008; // jr   $31
      dut.U_IM.ROM[17] = 32'hFC000000; // undefined -> NOP
      dut.U_IM.ROM[18] = 32'h08000012; // j    0x48 (loop)
   endtask

   task automatic load_second();
      dut.U_IM.ROM[0]  = 32'hFC000000; // undefined -> NOP
      dut.U_IM.ROM[1]  = 32'h20000007; // addi $0,$0,7
      dut.U_IM.ROM[2]  = 32'h8C080008; // lw   $8,8($0)
      dut.U_IM.ROM[3]  = 32'h2001FFF8; // addi $1,$0,-8
      dut.U_IM.ROM[4]  = 32'h00011043; // sra  $2,$1,1
      dut.U_IM.ROM[5]  = 32'h00011902; // srl  $3,$1,4
      dut.U_IM.ROM[6]  = 32'h0001202B; // sltu $4,$0,$1
      dut.U_IM.ROM[7]  = 32'h00282826; // xor  $5,$1,$8
      dut.U_IM.ROM[8]  = 32'h2826FFF9; // slti $6,$1,-7
      dut.U_IM.ROM[9]  = 32'h00013880; // sll  $7,$1,2
      dut.U_IM.ROM[10] = 32'h0800000A; // j    0x28 (loop)
   endtask

   initial begin
      int cyc;
      rstn    = 1'b1;
      reg_sel = '0;
      load_main();
      #2 rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;

      // Run part way, then reset mid-clock: state must clear with no edge
      repeat (5) step();
      exp_pc("pre_reset_pc", 32'h14);
      exp_reg("pre_reset_r5", 5'd5, 32'h1);
      drain();
      #2 rstn = 1'b0;
      #0.1;
      exp_pc("reset_pc", 32'h0);
      for (int i = 0; i < 32; i++) exp_reg($sformatf("reset_r%0d", i), i[4:0], 32'h0);
      drain();
      #10;
      exp_pc("reset_hold_pc", 32'h0);
      drain();
      @(negedge clk);
      rstn = 1'b1;

      // Main program, checked after each instruction
      step(); exp_pc("addi1_pc", 32'h04); exp_reg("addi1", 5'd1, 32'h5);        drain();
      step(); exp_pc("addi2_pc", 32'h08); exp_reg("addi2", 5'd2, 32'h3);        drain();
      step(); exp_pc("nor_pc",   32'h0C); exp_reg("nor",   5'd3, 32'hFFFFFFF8); drain();
      step(); exp_pc("sub_pc",   32'h10); exp_reg("sub",   5'd4, 32'hFFFFFFFE); drain();
      step(); exp_pc("slt_pc",   32'h14); exp_reg("slt",   5'd5, 32'h1);        drain();
      step(); exp_pc("lui_pc",   32'h18); exp_reg("lui",   5'd6, 32'h12340000); drain();
      step(); exp_pc("ori_pc",   32'h1C); exp_reg("ori",   5'd6, 32'h12345678); drain();
      step(); exp_pc("andi_pc",  32'h20); exp_reg("andi",  5'd7, 32'h00005678); drain();
      step(); exp_pc("beq_taken_pc", 32'h2C);                                     drain();
      step(); exp_pc("sw_pc",    32'h30); exp_reg("skipped_r9", 5'd9, 32'h0);   drain();
      step(); exp_pc("jal_pc",   32'h40); exp_reg("jal_ra", 5'd31, 32'h34);     drain();
      step(); exp_pc("jr_pc",    32'h34);                                         drain();
      step(); exp_pc("lw_pc",    32'h38); exp_reg("lw",    5'd8, 32'h12345678); drain();
      step(); exp_pc("bne_nt_pc", 32'h3C);                                        drain();
      step(); exp_pc("j_pc",     32'h44);                                         drain();
      step(); exp_pc("nop_pc",   32'h48);
      exp_reg("nop_r1", 5'd1, 32'h5); exp_reg("nop_r8", 5'd8, 32'h12345678);
      exp_reg("nop_r31", 5'd31, 32'h34); exp_reg("sel0", 5'd0, 32'h0);
      drain();

      // Termination loop must be reached within a bounded number of cycles
      cyc = 0;
      while (dut.PC !== 32'h48 && cyc < 1000) begin
         step();
         cyc++;
      end
      exp_pc("loop_reached", 32'h48);
      drain();
      repeat (3) step();
      exp_pc("loop_hold", 32'h48);
      exp_reg("loop_r6", 5'd6, 32'h12345678);
      drain();

      // Second reset mid-clock; data RAM must survive it
      #2 rstn = 1'b0;
      #0.1;
      exp_pc("reset2_pc", 32'h0);
      exp_reg("reset2_r6", 5'd6, 32'h0);
      exp_reg("reset2_r31", 5'd31, 32'h0);
      drain();
      load_second();
      @(negedge clk);
      rstn = 1'b1;

      step(); exp_pc("undef_pc", 32'h04); exp_reg("undef_r1", 5'd1, 32'h0);     drain();
      step(); exp_pc("addi_r0_pc", 32'h08); exp_rf0("addi_r0_store");
      exp_reg("addi_r0_port", 5'd0, 32'h0);                                      drain();
      step(); exp_reg("lw_after_reset", 5'd8, 32'h12345678);                     drain();
      step(); exp_reg("addi_neg", 5'd1, 32'hFFFFFFF8);                            drain();
      step(); exp_reg("sra",  5'd2, 32'hFFFFFFFC);                                drain();
      step(); exp_reg("srl",  5'd3, 32'h0FFFFFFF);                                drain();
      step(); exp_reg("sltu", 5'd4, 32'h1);                                       drain();
      step(); exp_reg("xor",  5'd5, 32'hEDCBA980);                                drain();
      step(); exp_reg("slti", 5'd6, 32'h1);                                       drain();
      step(); exp_reg("sll",  5'd7, 32'hFFFFFFE0); exp_pc("sll_pc", 32'h28);      drain();
      step(); exp_pc("loop2_pc", 32'h28);                                         drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
